// File: rtl/texture_loader_pkg.sv
// Shared constants and state encoding for the texture loader and the sprite read side.
// The CHK state exists only when TEXTURE_LOADER_CHKSUM_EN is defined.
package texture_loader_pkg;

    localparam int TEX_ADDR_W = 10;
    localparam int SLOT_W     = 2;
    localparam int WADDR_W    = SLOT_W + TEX_ADDR_W;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

`ifdef TEXTURE_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CHK, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_DONE} state_e;
`endif

    function automatic logic is_loading(input state_e s);
`ifdef TEXTURE_LOADER_CHKSUM_EN
        return (s == S_HI) || (s == S_LO) || (s == S_CHK);
`else
        return (s == S_HI) || (s == S_LO);
`endif
    endfunction

    // Field extractors for the sprite side, which decodes the same RGB565 words.
    function automatic logic [4:0] rgb565_r(input logic [15:0] w);
        return w[R_MSB:R_LSB];
    endfunction

    function automatic logic [5:0] rgb565_g(input logic [15:0] w);
        return w[G_MSB:G_LSB];
    endfunction

    function automatic logic [4:0] rgb565_b(input logic [15:0] w);
        return w[B_MSB:B_LSB];
    endfunction

endpackage

// File: rtl/texture_loader_chksum.sv
// Mod-256 byte accumulator with a registered compare against a trailing sum byte.
module texture_loader_chksum (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic       i_cmp,
    input  logic [7:0] i_byte,
    output logic       o_mismatch
);

    logic [7:0] sum_q;
    logic       mismatch_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sum_q      <= '0;
            mismatch_q <= 1'b0;
        end else if (i_clr) begin
            sum_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (i_add) begin
                sum_q <= sum_q + i_byte;
            end
            if (i_cmp) begin
                mismatch_q <= (i_byte != sum_q);
            end
        end
    end

    assign o_mismatch = mismatch_q;

endmodule

// File: rtl/texture_loader.sv
// Streams byte pairs into RGB565 texels and writes them to an external texture RAM slot.
// Optional trailing checksum byte and o_err flag enabled by TEXTURE_LOADER_CHKSUM_EN.
module texture_loader
    import texture_loader_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int SLOTS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_slot,
    input  logic        i_abort,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_we,
    output logic [11:0] o_waddr,
    output logic [15:0] o_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

`ifdef TEXTURE_LOADER_CHKSUM_EN
    localparam state_e S_AFTER_LAST = S_CHK;
`else
    localparam state_e S_AFTER_LAST = S_DONE;
`endif

    state_e                 state_q;
    logic [SLOT_W-1:0]      slot_q;
    logic [TEX_ADDR_W-1:0]  cnt_q;
    logic [7:0]             hi_q;
    logic                   we_q;
    logic [WADDR_W-1:0]     waddr_q;
    logic [15:0]            wdata_q;
    logic                   done_q;

    logic loading;
    logic start_ok;
    logic last_texel;

    assign loading    = is_loading(state_q);
    assign start_ok   = i_start && (state_q == S_IDLE) && (int'(i_slot) < SLOTS);
    assign last_texel = (cnt_q == TEX_ADDR_W'(WORDS - 1));

    // Abort is checked before i_valid in every loading state so it always wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        slot_q  <= i_slot;
                        cnt_q   <= '0;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (i_abort) begin
                        state_q <= S_IDLE;
                    end else if (i_valid) begin
                        hi_q    <= i_byte;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (i_abort) begin
                        state_q <= S_IDLE;
                    end else if (i_valid) begin
                        we_q    <= 1'b1;
                        waddr_q <= {slot_q, cnt_q};
                        wdata_q <= {hi_q, i_byte};
                        if (last_texel) begin
                            state_q <= S_AFTER_LAST;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= S_HI;
                        end
                    end
                end
`ifdef TEXTURE_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (i_abort) begin
                        state_q <= S_IDLE;
                    end else if (i_valid) begin
                        state_q <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready = loading;
    assign o_busy  = loading;
    assign o_we    = we_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_done  = done_q;

`ifdef TEXTURE_LOADER_CHKSUM_EN
    logic xfer;
    logic mismatch;
    logic err_q;

    assign xfer = i_valid && loading && !i_abort;

    texture_loader_chksum u_chksum (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (start_ok),
        .i_add      (xfer && (state_q != S_CHK)),
        .i_cmp      (xfer && (state_q == S_CHK)),
        .i_byte     (i_byte),
        .o_mismatch (mismatch)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            err_q <= mismatch;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_texture_loader.sv
// Self-checking bench for texture_loader: byte-level protocol model plus literal pins.
// Also exercises the trailing checksum when TEXTURE_LOADER_CHKSUM_EN is defined.
module tb_texture_loader;

    localparam int NB = 2048;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_slot;
    logic        i_abort;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        o_ready;
    logic        o_we;
    logic [11:0] o_waddr;
    logic [15:0] o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    texture_loader #(.WORDS(1024), .SLOTS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_slot  (i_slot),
        .i_abort (i_abort),
        .i_byte  (i_byte),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_we    (o_we),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, written by the stimulus process.
    logic        chk_en = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_we = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_zero = 1'b1;
    logic [11:0] exp_waddr = '0;
    logic [15:0] exp_wdata = '0;

    int          nwrites = 0;
    int          ndone = 0;
    int          load_mark = 0;
    logic [11:0] first_addr = '0;
    logic [11:0] last_addr = '0;
    logic [15:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_ready", 32'(o_ready), 32'(exp_ready));
            chk("o_busy", 32'(o_busy), 32'(exp_busy));
            chk("o_we", 32'(o_we), 32'(exp_we));
            chk("o_done", 32'(o_done), 32'(exp_done));
            chk("o_err", 32'(o_err), 32'(exp_err));
            if (exp_we || exp_zero) begin
                chk("o_waddr", 32'(o_waddr), 32'(exp_waddr));
                chk("o_wdata", 32'(o_wdata), 32'(exp_wdata));
            end
            if (o_we === 1'b1) begin
                if (nwrites == load_mark) first_addr = o_waddr;
                nwrites++;
                last_addr = o_waddr;
                last_data = o_wdata;
            end
            if (o_done === 1'b1) ndone++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        exp_we    = 1'b0;
        exp_done  = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input int pat, input int k);
        if (pat == 0) return (k % 2 == 0) ? 8'hF8 : 8'h00;
        return 8'((k * 37 + 11) & 255);
    endfunction

    // Drives one load; the k-th accepted byte is byte_of(pat,k). Every odd byte
    // completes texel k/2, which must appear on the write port in the following cycle.
    task automatic run_load(input int slot, input int pat, input bit gaps,
                            input int abort_k, input int rst_k, input int start_k,
                            input bit bad_sum);
        int          k;
        int          guard;
        bit          v;
        bit          pend;
        bit          aborted;
        bit          rstd;
        logic [11:0] paddr;
        logic [15:0] pdata;
`ifdef TEXTURE_LOADER_CHKSUM_EN
        logic [7:0]  sum;
        sum = '0;
`endif
        k = 0; guard = 0; pend = 0; aborted = 0; rstd = 0;
        paddr = '0; pdata = '0;
        load_mark = nwrites;
        exp_zero = 1'b0;
        set_idle_exp();
        i_start = 1'b1;
        i_slot  = 2'(slot);
        tick();
        i_start = 1'b0;
        exp_err = 1'b0;
        while (k < NB) begin
            exp_we    = pend;
            exp_waddr = paddr;
            exp_wdata = pdata;
            exp_ready = 1'b1;
            exp_busy  = 1'b1;
            exp_done  = 1'b0;
            pend = 0;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_valid = v;
            i_byte  = byte_of(pat, k);
            i_abort = (k == abort_k) && v;
            i_start = (k == start_k);
            i_slot  = 2'(slot + 1);
            if (k == rst_k) i_rst_n = 1'b0;
            tick();
            i_start = 1'b0;
            if (!i_rst_n) begin
                rstd = 1; i_rst_n = 1'b1; i_valid = 1'b0;
                break;
            end
            if (i_abort) begin
                aborted = 1; i_abort = 1'b0; i_valid = 1'b0;
                break;
            end
            if (v) begin
`ifdef TEXTURE_LOADER_CHKSUM_EN
                sum = sum + byte_of(pat, k);
`endif
                if (k % 2 == 1) begin
                    pend  = 1;
                    paddr = {2'(slot), 10'(k / 2)};
                    pdata = {byte_of(pat, k - 1), byte_of(pat, k)};
                end
                k++;
            end
            guard++;
            if (guard > 20000) begin
                n_errors++;
                $display("FAIL load_timeout: got %0d bytes expected %0d", k, NB);
                i_valid = 1'b0;
                set_idle_exp();
                return;
            end
        end
        i_valid = 1'b0;
        if (rstd) begin
            set_idle_exp();
            exp_err = 1'b0; exp_zero = 1'b1;
            exp_waddr = '0; exp_wdata = '0;
            repeat (4) tick();
        end else if (aborted) begin
            set_idle_exp();
            repeat (4) tick();
        end else begin
            exp_we = 1'b1; exp_waddr = paddr; exp_wdata = pdata;
`ifdef TEXTURE_LOADER_CHKSUM_EN
            exp_ready = 1'b1; exp_busy = 1'b1;
            i_valid = 1'b1;
            i_byte  = sum ^ {7'b0, bad_sum};
            tick();
            i_valid = 1'b0;
            set_idle_exp();
            tick();
            exp_done = 1'b1;
            exp_err  = bad_sum;
`else
            if (bad_sum) $display("note: checksum disabled, bad_sum ignored");
            exp_ready = 1'b0; exp_busy = 1'b0;
            tick();
            exp_we = 1'b0; exp_done = 1'b1;
`endif
            tick();
            exp_done = 1'b0;
            repeat (2) tick();
        end
    endtask

    int w0;
    int d0;

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_slot = '0; i_abort = 1'b0;
        i_byte = '0; i_valid = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        i_rst_n = 1'b1;
        repeat (2) tick();
        exp_zero = 1'b0;

        // Slot 2, 0xF8/0x00 back-to-back.
        w0 = nwrites; d0 = ndone;
        run_load(2, 0, 0, -1, -1, -1, 0);
        chk("A_writes", 32'(nwrites - w0), 32'd1024);
        chk("A_first_addr", 32'(first_addr), 32'h800);
        chk("A_last_addr", 32'(last_addr), 32'hBFF);
        chk("A_last_data", 32'(last_data), 32'hF800);
        chk("A_done_count", 32'(ndone - d0), 32'd1);

        // Slot 1, varied bytes, random valid gaps.
        w0 = nwrites; d0 = ndone;
        run_load(1, 1, 1, -1, -1, -1, 0);
        chk("B_writes", 32'(nwrites - w0), 32'd1024);
        chk("B_last_addr", 32'(last_addr), 32'h7FF);
        chk("B_last_data", 32'(last_data), 32'hC1E6);
        chk("B_done_count", 32'(ndone - d0), 32'd1);

        // Abort with the LO byte of texel 5.
        w0 = nwrites; d0 = ndone;
        run_load(0, 1, 0, 11, -1, -1, 0);
        chk("C_writes", 32'(nwrites - w0), 32'd5);
        chk("C_last_addr", 32'(last_addr), 32'h004);
        chk("C_done_count", 32'(ndone - d0), 32'd0);

        // Fresh load after abort starts again from texel 0.
        w0 = nwrites; d0 = ndone;
        run_load(0, 0, 0, -1, -1, -1, 0);
        chk("D_first_addr", 32'(first_addr), 32'h000);
        chk("D_writes", 32'(nwrites - w0), 32'd1024);

        // Ignored mid-load start, then reset at texel 300.
        w0 = nwrites; d0 = ndone;
        run_load(1, 1, 0, -1, 600, 100, 0);
        chk("E_writes", 32'(nwrites - w0), 32'd300);
        chk("E_last_addr", 32'(last_addr), 32'h52B);
        chk("E_done_count", 32'(ndone - d0), 32'd0);
        chk("E_waddr_after_rst", 32'(o_waddr), 32'h000);

`ifdef TEXTURE_LOADER_CHKSUM_EN
        run_load(2, 0, 0, -1, -1, -1, 1);
        chk("G_err_bad_sum", 32'(o_err), 32'd1);
`endif

        // Slot 3 ends at the top of the address space without wrapping.
        w0 = nwrites; d0 = ndone;
        run_load(3, 1, 0, -1, -1, -1, 0);
        chk("F_writes", 32'(nwrites - w0), 32'd1024);
        chk("F_first_addr", 32'(first_addr), 32'hC00);
        chk("F_last_addr", 32'(last_addr), 32'hFFF);
        chk("F_done_count", 32'(ndone - d0), 32'd1);
        chk("F_err", 32'(o_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
